// File: rtl/keypad_lock_ctrl_if.sv
// Keypad-to-lock-controller signal bundle: raw key level/code in, decoded key and lock status out.
// master drives the keypad side, slave is the lock controller.
interface keypad_lock_ctrl_if;
  logic        press;
  logic [3:0]  scan_code;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [2:0]  digit_cnt;
  logic [15:0] entry;
  logic        unlock;
  logic        error;
  logic        locked;

  modport master (
    output press, scan_code,
    input  key_valid, key_code, digit_cnt, entry, unlock, error, locked
  );

  modport slave (
    input  press, scan_code,
    output key_valid, key_code, digit_cnt, entry, unlock, error, locked
  );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// Debounced keypad code lock: key_valid DEB_CYC+1 cycles after first press sample, error one cycle after key_valid.
// No backpressure (level input); define LOCKOUT_EN to lock out all keys for LOCK_CYC cycles after three failed enters.
module keypad_lock_ctrl #(
  parameter int unsigned DEB_CYC  = 4,
  parameter logic [15:0] PASSWORD = 16'h1234,
  parameter int unsigned LOCK_CYC = 1000
) (
  input logic               clk,
  input logic               rst,
  keypad_lock_ctrl_if.slave kp
);

  typedef enum logic [1:0] {IDLE, DEB, ACCEPT, WAIT_REL} state_t;

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  state_t        state;
  logic [DW-1:0] deb_cnt;
  logic [3:0]    cap_code;
  logic          key_valid;
  logic [3:0]    key_code;
  logic [2:0]    digit_cnt;
  logic [15:0]   entry;
  logic          unlock;
  logic          err_pend;
  logic          error;
  logic [1:0]    fail_cnt;
  logic          hold_idle;

`ifdef LOCKOUT_EN
  localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);

  logic          locked;
  logic [LW-1:0] lock_cnt;

  assign hold_idle = locked;
  assign kp.locked = locked;
`else
  assign hold_idle = 1'b0;
  assign kp.locked = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      cap_code  <= 4'h0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digit_cnt <= 3'd0;
      entry     <= 16'h0;
      unlock    <= 1'b0;
      err_pend  <= 1'b0;
      error     <= 1'b0;
      fail_cnt  <= 2'd0;
`ifdef LOCKOUT_EN
      locked    <= 1'b0;
      lock_cnt  <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      err_pend  <= 1'b0;
      error     <= err_pend;
`ifdef LOCKOUT_EN
      if (locked) begin
        if (lock_cnt == LOCK_LAST) begin
          locked   <= 1'b0;
          lock_cnt <= '0;
          fail_cnt <= 2'd0;
        end else begin
          lock_cnt <= lock_cnt + LW'(1);
        end
      end
`endif
      if (hold_idle) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (kp.press) begin
              state    <= DEB;
              cap_code <= kp.scan_code;
              deb_cnt  <= '0;
            end
          end
          DEB: begin
            if (!kp.press || (kp.scan_code != cap_code)) begin
              state <= IDLE;
            end else if (deb_cnt == DEB_LAST) begin
              state <= ACCEPT;
            end else begin
              deb_cnt <= deb_cnt + DW'(1);
            end
          end
          ACCEPT: begin
            // Input is not looked at here, so a release during ACCEPT is seen in WAIT_REL.
            state     <= WAIT_REL;
            key_valid <= 1'b1;
            key_code  <= cap_code;
            if (cap_code <= 4'd9) begin
              if (digit_cnt != 3'd4) begin
                entry     <= {entry[11:0], cap_code};
                digit_cnt <= digit_cnt + 3'd1;
              end
            end else if (cap_code == 4'hB) begin
              entry     <= 16'h0;
              digit_cnt <= 3'd0;
              unlock    <= 1'b0;
            end else if (cap_code == 4'hA) begin
              entry     <= 16'h0;
              digit_cnt <= 3'd0;
              if ((digit_cnt == 3'd4) && (entry == PASSWORD)) begin
                unlock   <= 1'b1;
                fail_cnt <= 2'd0;
              end else begin
                err_pend <= 1'b1;
                if (fail_cnt != 2'd3) begin
                  fail_cnt <= fail_cnt + 2'd1;
                end
`ifdef LOCKOUT_EN
                if (fail_cnt == 2'd2) begin
                  locked   <= 1'b1;
                  lock_cnt <= '0;
                end
`endif
              end
            end
          end
          WAIT_REL: begin
            if (!kp.press) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign kp.key_valid = key_valid;
  assign kp.key_code  = key_code;
  assign kp.digit_cnt = digit_cnt;
  assign kp.entry     = entry;
  assign kp.unlock    = unlock;
  assign kp.error     = error;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed self-checking bench for keypad_lock_ctrl; covers both LOCKOUT_EN builds.
module tb_keypad_lock_ctrl;
  localparam int DEB_CYC  = 4;
  localparam int LOCK_CYC = 1000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   kv_cnt;
  int   err_cnt;
  int   lock_cyc;

  keypad_lock_ctrl_if kp ();

  keypad_lock_ctrl #(
    .DEB_CYC (DEB_CYC),
    .PASSWORD(16'h1234),
    .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) kv_cnt++;
    if (kp.error === 1'b1) err_cnt++;
    if (kp.locked === 1'b1) lock_cyc++;
  end

  task automatic press_key(input logic [3:0] code, input int hold);
    kp.scan_code = code;
    kp.press     = 1'b1;
    repeat (hold) @(negedge clk);
    kp.press     = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    kp.press = 1'b0;
    kp.scan_code = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b want 0", kp.key_valid); end
    n_cmp++; if (kp.key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h want 0", kp.key_code); end
    n_cmp++; if (kp.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_digit_cnt: got %0d want 0", kp.digit_cnt); end
    n_cmp++; if (kp.entry !== 16'h0) begin n_fail++; $display("FAIL reset_entry: got %h want 0000", kp.entry); end
    n_cmp++; if ({kp.unlock, kp.error, kp.locked} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {kp.unlock, kp.error, kp.locked}); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unlock;
    logic [3:0] digits [4];
    int kv0;
    int err0;
    digits = '{4'h1, 4'h2, 4'h3, 4'h4};
    kv0 = kv_cnt;
    err0 = err_cnt;
    for (int i = 0; i < 4; i++) begin
      press_key(digits[i], 10);
      n_cmp++; if (kp.digit_cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL unlock_digit_cnt[%0d]: got %0d want %0d", i, kp.digit_cnt, i + 1); end
    end
    n_cmp++; if (kp.entry !== 16'h1234) begin n_fail++; $display("FAIL unlock_entry: got %h want 1234", kp.entry); end
    press_key(4'hA, 10);
    n_cmp++; if (kp.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL unlock_cnt_after_enter: got %0d want 0", kp.digit_cnt); end
    n_cmp++; if (kp.unlock !== 1'b1) begin n_fail++; $display("FAIL unlock_level: got %b want 1", kp.unlock); end
    n_cmp++; if (kv_cnt - kv0 !== 5) begin n_fail++; $display("FAIL unlock_key_valid_count: got %0d want 5", kv_cnt - kv0); end
    n_cmp++; if (err_cnt - err0 !== 0) begin n_fail++; $display("FAIL unlock_error_count: got %0d want 0", err_cnt - err0); end
  endtask

  task automatic test_latency_hold;
    int lat;
    int kv0;
    kv0 = kv_cnt;
    lat = -1;
    kp.scan_code = 4'h7;
    kp.press = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (kp.key_valid === 1'b1) begin lat = c; break; end
    end
    n_cmp++; if (lat !== DEB_CYC + 1) begin n_fail++; $display("FAIL accept_latency: got %0d want %0d", lat, DEB_CYC + 1); end
    n_cmp++; if (kp.key_code !== 4'h7) begin n_fail++; $display("FAIL latency_key_code: got %h want 7", kp.key_code); end
    repeat (30) @(negedge clk);
    kp.press = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (kv_cnt - kv0 !== 1) begin n_fail++; $display("FAIL held_key_pulses: got %0d want 1", kv_cnt - kv0); end
    n_cmp++; if ({kp.unlock, kp.digit_cnt, kp.entry} !== {1'b1, 3'd1, 16'h0007}) begin n_fail++; $display("FAIL unlocked_digit_store: got %b/%0d/%h want 1/1/0007", kp.unlock, kp.digit_cnt, kp.entry); end
    press_key(4'hB, 10);
    n_cmp++; if ({kp.unlock, kp.digit_cnt, kp.entry} !== {1'b0, 3'd0, 16'h0}) begin n_fail++; $display("FAIL clear_after_unlock: got %b/%0d/%h want 0/0/0000", kp.unlock, kp.digit_cnt, kp.entry); end
  endtask

  task automatic test_glitch;
    int kv0;
    kv0 = kv_cnt;
    kp.scan_code = 4'h5;
    for (int i = 0; i < 10; i++) begin
      kp.press = 1'b1;
      repeat (2) @(negedge clk);
      kp.press = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    n_cmp++; if (kv_cnt - kv0 !== 0) begin n_fail++; $display("FAIL glitch_key_valid: got %0d want 0", kv_cnt - kv0); end
    n_cmp++; if (kp.entry !== 16'h0) begin n_fail++; $display("FAIL glitch_entry: got %h want 0000", kp.entry); end
  endtask

  task automatic test_short_enter;
    int err0;
    bit seen;
    err0 = err_cnt;
    seen = 1'b0;
    press_key(4'h1, 10);
    press_key(4'h2, 10);
    press_key(4'h3, 10);
    kp.scan_code = 4'hA;
    kp.press = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (kp.key_valid === 1'b1) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL short_enter_accept: got %b want 1", seen); end
    n_cmp++; if (kp.error !== 1'b0) begin n_fail++; $display("FAIL error_with_key_valid: got %b want 0", kp.error); end
    @(negedge clk);
    n_cmp++; if (kp.error !== 1'b1) begin n_fail++; $display("FAIL error_next_cycle: got %b want 1", kp.error); end
    @(negedge clk);
    n_cmp++; if (kp.error !== 1'b0) begin n_fail++; $display("FAIL error_one_cycle: got %b want 0", kp.error); end
    kp.press = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (err_cnt - err0 !== 1) begin n_fail++; $display("FAIL short_enter_error_count: got %0d want 1", err_cnt - err0); end
    n_cmp++; if ({kp.unlock, kp.digit_cnt} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL short_enter_state: got %b/%0d want 0/0", kp.unlock, kp.digit_cnt); end
  endtask

  task automatic test_overflow;
    int kv0;
    kv0 = kv_cnt;
    press_key(4'h1, 10);
    press_key(4'h2, 10);
    press_key(4'h3, 10);
    press_key(4'h4, 10);
    press_key(4'h5, 10);
    n_cmp++; if ({kp.digit_cnt, kp.entry} !== {3'd4, 16'h1234}) begin n_fail++; $display("FAIL overflow_discard: got %0d/%h want 4/1234", kp.digit_cnt, kp.entry); end
    press_key(4'hE, 10);
    n_cmp++; if (kp.key_code !== 4'hE) begin n_fail++; $display("FAIL ignored_code_key: got %h want e", kp.key_code); end
    n_cmp++; if ({kp.digit_cnt, kp.entry, kp.unlock} !== {3'd4, 16'h1234, 1'b0}) begin n_fail++; $display("FAIL ignored_code_effect: got %0d/%h/%b want 4/1234/0", kp.digit_cnt, kp.entry, kp.unlock); end
    n_cmp++; if (kv_cnt - kv0 !== 6) begin n_fail++; $display("FAIL overflow_key_valid_count: got %0d want 6", kv_cnt - kv0); end
    press_key(4'hB, 10);
    n_cmp++; if ({kp.digit_cnt, kp.entry} !== {3'd0, 16'h0}) begin n_fail++; $display("FAIL clear_entry: got %0d/%h want 0/0000", kp.digit_cnt, kp.entry); end
  endtask

  task automatic test_lockout;
    int kv0;
    int err0;
    int lk0;
    press_key(4'h1, 10);
    press_key(4'h2, 10);
    press_key(4'h3, 10);
    press_key(4'h4, 10);
    press_key(4'hA, 10);
    press_key(4'hB, 10);
    err0 = err_cnt;
    lk0 = lock_cyc;
    press_key(4'hA, 10);
    press_key(4'hA, 10);
    press_key(4'hA, 10);
    n_cmp++; if (err_cnt - err0 !== 3) begin n_fail++; $display("FAIL three_fail_errors: got %0d want 3", err_cnt - err0); end
    kv0 = kv_cnt;
`ifdef LOCKOUT_EN
    n_cmp++; if (kp.locked !== 1'b1) begin n_fail++; $display("FAIL lockout_set: got %b want 1", kp.locked); end
    press_key(4'h1, 10);
    n_cmp++; if (kv_cnt - kv0 !== 0) begin n_fail++; $display("FAIL lockout_key_ignored: got %0d want 0", kv_cnt - kv0); end
    for (int c = 0; c < 2 * LOCK_CYC; c++) begin
      if (kp.locked !== 1'b1) break;
      @(negedge clk);
    end
    n_cmp++; if (lock_cyc - lk0 !== LOCK_CYC) begin n_fail++; $display("FAIL lockout_duration: got %0d want %0d", lock_cyc - lk0, LOCK_CYC); end
`else
    n_cmp++; if (lock_cyc - lk0 !== 0) begin n_fail++; $display("FAIL no_lockout: got %0d locked cycles want 0", lock_cyc - lk0); end
`endif
    press_key(4'h1, 10);
    n_cmp++; if (kv_cnt - kv0 !== 1) begin n_fail++; $display("FAIL key_after_failures: got %0d want 1", kv_cnt - kv0); end
    n_cmp++; if ({kp.digit_cnt, kp.locked} !== {3'd1, 1'b0}) begin n_fail++; $display("FAIL state_after_failures: got %0d/%b want 1/0", kp.digit_cnt, kp.locked); end
    press_key(4'hB, 10);
  endtask

  task automatic test_reset_mid_debounce;
    int lat;
    press_key(4'h1, 10);
    press_key(4'h2, 10);
    press_key(4'h3, 10);
    press_key(4'h4, 10);
    press_key(4'hA, 10);
    press_key(4'h5, 10);
    n_cmp++; if ({kp.unlock, kp.digit_cnt} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL pre_reset_state: got %b/%0d want 1/1", kp.unlock, kp.digit_cnt); end
    kp.scan_code = 4'h9;
    kp.press = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({kp.key_valid, kp.unlock, kp.error, kp.locked} !== 4'b0000) begin n_fail++; $display("FAIL async_reset_flags: got %b want 0000", {kp.key_valid, kp.unlock, kp.error, kp.locked}); end
    n_cmp++; if ({kp.key_code, kp.digit_cnt, kp.entry} !== {4'h0, 3'd0, 16'h0}) begin n_fail++; $display("FAIL async_reset_data: got %h/%0d/%h want 0/0/0000", kp.key_code, kp.digit_cnt, kp.entry); end
    @(negedge clk);
    rst = 1'b1;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (kp.key_valid === 1'b1) begin lat = c; break; end
    end
    n_cmp++; if (lat !== DEB_CYC + 1) begin n_fail++; $display("FAIL post_reset_latency: got %0d want %0d", lat, DEB_CYC + 1); end
    kp.press = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if ({kp.key_code, kp.digit_cnt, kp.entry} !== {4'h9, 3'd1, 16'h0009}) begin n_fail++; $display("FAIL post_reset_key: got %h/%0d/%h want 9/1/0009", kp.key_code, kp.digit_cnt, kp.entry); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    kv_cnt = 0;
    err_cnt = 0;
    lock_cyc = 0;
    test_reset;
    test_unlock;
    test_latency_hold;
    test_glitch;
    test_overflow;
    test_short_enter;
    test_lockout;
    test_reset_mid_debounce;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_lock_ctrl.md
KEYPAD_LOCK_CTRL -- requirements
Module: keypad_lock_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYC, default 4, giving the number of cycles press and scan_code must stay stable before a key is accepted.
REQ-002 The block SHALL have parameter PASSWORD, default 16'h1234, holding four BCD digits, most significant digit entered first.
REQ-003 The block SHALL have parameter LOCK_CYC, default 1000, giving the lockout duration in cycles.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 press  input  1  level from keypad decoder; 1 = a key is down.
REQ-007 scan_code  input  4  code of the pressed key; 0-9 digits, A = enter, B = clear, C-F ignored.
REQ-008 key_valid  output  1  one-cycle strobe per accepted key.
REQ-009 key_code  output  4  code of the last accepted key.
REQ-010 digit_cnt  output  3  digits currently held, 0-4.
REQ-011 entry  output  16  held digits, newest digit in [3:0].
REQ-012 unlock  output  1  level; 1 = correct code entered.
REQ-013 error  output  1  one-cycle strobe on a wrong or short enter.
REQ-014 locked  output  1  1 = lockout active; all keys ignored.

Function
REQ-015 Key FSM SHALL have states IDLE, DEB, ACCEPT and WAIT_REL.
- IDLE -> DEB when press = 1; capture scan_code and clear the stability counter.
- DEB -> IDLE if press drops or scan_code differs from the captured code.
- DEB -> ACCEPT when the counter reaches DEB_CYC-1.
REQ-016 ACCEPT SHALL last exactly one cycle, assert key_valid, load key_code, and go to WAIT_REL.
REQ-017 WAIT_REL SHALL return to IDLE only after press = 0 for one cycle; a held key SHALL produce exactly one key_valid.
REQ-018 Accept latency SHALL be DEB_CYC+1 cycles from the first press sample to key_valid.
REQ-019 On an accepted digit with digit_cnt < 4, the block SHALL shift entry left 4 bits, insert the digit, and increment digit_cnt.
REQ-020 On an accepted digit with digit_cnt = 4, the block SHALL discard the digit with entry and digit_cnt unchanged; there is no wrap.
REQ-021 Accepted B SHALL clear entry and digit_cnt and deassert unlock.
REQ-022 Accepted A with digit_cnt = 4 and entry = PASSWORD SHALL set unlock, clear the failure counter, and clear entry and digit_cnt.
REQ-023 Accepted A in any other case SHALL pulse error for one cycle the cycle after key_valid, increment the 2-bit failure counter (saturating), and clear entry and digit_cnt.
REQ-024 unlock SHALL stay 1 until B is accepted or reset; digits entered while unlocked SHALL be stored normally.
REQ-025 Codes C-F SHALL generate key_valid but SHALL have no other effect.
REQ-026 If press changes while in ACCEPT, the change SHALL be ignored until WAIT_REL.

Reset
REQ-027 rst = 0 SHALL immediately force the key FSM to IDLE.
REQ-028 rst = 0 SHALL clear all counters, key_valid, key_code, digit_cnt, entry, unlock, error and locked to 0, including mid-debounce and mid-lockout.
REQ-029 The first key after reset release SHALL require a full debounce.

Configuration
REQ-030 With LOCKOUT_EN defined, the third consecutive failure SHALL set locked for LOCK_CYC cycles.
- While locked, the key FSM SHALL be held in IDLE and no key_valid SHALL occur.
- On expiry, locked and the failure counter SHALL clear.
REQ-031 Without LOCKOUT_EN, locked SHALL be tied to 0, the lockout counter SHALL be absent, and failures SHALL only pulse error.

Verification
REQ-032 Reset, then press 1,2,3,4,A (each held 10 cycles, 5-cycle gaps) -> five key_valid pulses, digit_cnt 1,2,3,4,0, unlock = 1, error never set.
REQ-033 Press toggling with a 2-cycle high and DEB_CYC = 4 -> no key_valid, entry stays 0.
REQ-034 Enter 1,2,3 then A -> error pulses once, unlock = 0, digit_cnt = 0.
REQ-035 Enter 1,2,3,4,5 -> entry = 16'h1234, digit_cnt = 4; then B -> entry = 0.
REQ-036 Under LOCKOUT_EN, three wrong enters followed by key 1 -> locked = 1 for 1000 cycles, no key_valid; key 1 after expiry -> accepted, digit_cnt = 1.
REQ-037 Assert rst = 0 during DEB while unlock = 1 -> all outputs are 0 in the same cycle, and the next key needs DEB_CYC+1 cycles.
